// File: rtl/lcd_write_controller_if.sv
// ============================================================================
// Module      : lcd_write_controller_if
// Description : Pin and handshake bundle between the ASCII decoder, the LCD
//               write controller and the HD44780 character LCD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_write_controller_if;
    logic [87:0] lcd_value;
    logic        refresh;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic        busy;
    logic        frame_done;

    modport master (
        input  lcd_value, refresh,
        output lcd_data, lcd_rs, lcd_rw, lcd_e, busy, frame_done
    );

    modport slave (
        output lcd_value, refresh,
        input  lcd_data, lcd_rs, lcd_rw, lcd_e, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/lcd_write_controller.sv
// ============================================================================
// Module      : lcd_write_controller
// Description : HD44780 8-bit write controller: power-up init, then one
//               coherent 17-write frame per refresh request.
//               Optional LCD_FRAME_SKIP_EN: skip frames whose content is
//               unchanged since the last written frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_write_controller #(
    parameter int PWRUP_WAIT_CYC = 750000,
    parameter int EN_PULSE_CYC   = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLR_WAIT_CYC   = 82000
) (
    input  logic                   clk,
    input  logic                   reset,
    lcd_write_controller_if.master bus
);

    localparam int c_MAX_A   = (PWRUP_WAIT_CYC > EN_PULSE_CYC) ? PWRUP_WAIT_CYC : EN_PULSE_CYC;
    localparam int c_MAX_B   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int c_MAX_CYC = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_PWRUP_LAST = c_CNT_W'(PWRUP_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CMD_LAST   = c_CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CLR_LAST   = c_CNT_W'(CLR_WAIT_CYC - 1);

    // Write slots 0..3 are the init commands, 4..20 the frame.
    localparam logic [4:0] c_IDX_CLEAR  = 5'd3;
    localparam logic [4:0] c_IDX_FRAME0 = 5'd4;
    localparam logic [4:0] c_IDX_LAST   = 5'd20;

    localparam logic [2:0] c_ST_PWRUP = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_PULSE = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_IDLE  = 3'd4;
    localparam logic [2:0] c_ST_LOAD  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_last;
    logic               w_cnt_done;
    logic [4:0]         r_idx;
    logic [4:0]         w_idx_next;
    logic [87:0]        r_snap;
    logic [7:0]         r_data;
    logic               r_rs;
    logic               r_e;
    logic               w_frame_done;
    logic               w_go;

    // {rs, data} for each write slot; frame data comes only from the snapshot.
    function automatic logic [8:0] write_word(input logic [4:0] idx, input logic [87:0] snap);
        case (idx)
            5'd0:    write_word = {1'b0, 8'h38};
            5'd1:    write_word = {1'b0, 8'h0C};
            5'd2:    write_word = {1'b0, 8'h06};
            5'd3:    write_word = {1'b0, 8'h01};
            5'd4:    write_word = {1'b0, 8'h80};
            5'd5:    write_word = {1'b1, snap[47:40]};
            5'd6:    write_word = {1'b1, snap[39:32]};
            5'd7:    write_word = {1'b1, 8'h3A};
            5'd8:    write_word = {1'b1, snap[31:24]};
            5'd9:    write_word = {1'b1, snap[23:16]};
            5'd10:   write_word = {1'b1, 8'h3A};
            5'd11:   write_word = {1'b1, snap[15:8]};
            5'd12:   write_word = {1'b1, snap[7:0]};
            5'd13:   write_word = {1'b0, 8'h8F};
            5'd14:   write_word = {1'b1, snap[87:80]};
            5'd15:   write_word = {1'b0, 8'hC0};
            5'd16:   write_word = {1'b1, snap[79:72]};
            5'd17:   write_word = {1'b1, snap[71:64]};
            5'd18:   write_word = {1'b1, 8'h2F};
            5'd19:   write_word = {1'b1, snap[63:56]};
            5'd20:   write_word = {1'b1, snap[55:48]};
            default: write_word = 9'h000;
        endcase
    endfunction

`ifdef LCD_FRAME_SKIP_EN
    logic r_have_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_have_frame <= 1'b0;
        end else if (r_state == c_ST_LOAD) begin
            r_have_frame <= 1'b1;
        end
    end

    assign w_go = !r_have_frame || (bus.lcd_value != r_snap);
`else
    assign w_go = 1'b1;
`endif

    always_comb begin
        w_last = '0;
        case (r_state)
            c_ST_PWRUP: w_last = c_PWRUP_LAST;
            c_ST_PULSE: w_last = c_PULSE_LAST;
            c_ST_WAIT:  w_last = (r_idx == c_IDX_CLEAR) ? c_CLR_LAST : c_CMD_LAST;
            default:    w_last = '0;
        endcase
    end

    assign w_cnt_done = (r_cnt == w_last);

    always_comb begin
        w_next       = r_state;
        w_idx_next   = r_idx;
        w_frame_done = 1'b0;
        case (r_state)
            c_ST_PWRUP: if (w_cnt_done) w_next = c_ST_SETUP;
            c_ST_SETUP: w_next = c_ST_PULSE;
            c_ST_PULSE: if (w_cnt_done) w_next = c_ST_WAIT;
            c_ST_WAIT: begin
                if (w_cnt_done) begin
                    if (r_idx == c_IDX_LAST) begin
                        w_next       = c_ST_IDLE;
                        w_frame_done = 1'b1;
                    end else if (r_idx == c_IDX_CLEAR) begin
                        w_next = c_ST_IDLE;
                    end else begin
                        w_next     = c_ST_SETUP;
                        w_idx_next = r_idx + 5'd1;
                    end
                end
            end
            c_ST_IDLE: if (bus.refresh && w_go) w_next = c_ST_LOAD;
            c_ST_LOAD: begin
                w_next     = c_ST_SETUP;
                w_idx_next = c_IDX_FRAME0;
            end
            default: w_next = c_ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_PWRUP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            // Counter only runs inside timed states, restarting on every state change.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == c_ST_PWRUP || r_state == c_ST_PULSE || r_state == c_ST_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_e <= (w_next == c_ST_PULSE);
            if (w_next == c_ST_SETUP) begin
                {r_rs, r_data} <= write_word(w_idx_next, r_snap);
            end
            if (r_state == c_ST_IDLE && w_next == c_ST_LOAD) begin
                r_snap <= bus.lcd_value;
            end
        end
    end

    assign bus.lcd_data   = r_data;
    assign bus.lcd_rs     = r_rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = r_e;
    assign bus.busy       = (r_state != c_ST_IDLE);
    assign bus.frame_done = w_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_controller.sv
// ============================================================================
// Module      : tb_lcd_write_controller
// Description : Scoreboard bench for lcd_write_controller with a frame-level
//               reference model. Honours LCD_FRAME_SKIP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_write_controller;

    localparam int c_PWRUP = 20;
    localparam int c_EN    = 2;
    localparam int c_CMD   = 5;
    localparam int c_CLR   = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd_write_controller_if bus ();

    lcd_write_controller #(
        .PWRUP_WAIT_CYC (c_PWRUP),
        .EN_PULSE_CYC   (c_EN),
        .CMD_WAIT_CYC   (c_CMD),
        .CLR_WAIT_CYC   (c_CLR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_word;
    logic        prev_e = 1'b0;
    logic [87:0] prev_v = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // Reference frame: line 1 "hh:mm:ss" at col 0, mode at col 15; line 2 "mo/dd".
    task automatic push_frame(input logic [87:0] v);
        logic [7:0] b [11];
        for (int k = 0; k < 11; k++) b[k] = v[8*k +: 8];
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b1, b[5]});
        exp_q.push_back({1'b1, b[4]});
        exp_q.push_back({1'b1, 8'h3A});
        exp_q.push_back({1'b1, b[3]});
        exp_q.push_back({1'b1, b[2]});
        exp_q.push_back({1'b1, 8'h3A});
        exp_q.push_back({1'b1, b[1]});
        exp_q.push_back({1'b1, b[0]});
        exp_q.push_back({1'b0, 8'h8F});
        exp_q.push_back({1'b1, b[10]});
        exp_q.push_back({1'b0, 8'hC0});
        exp_q.push_back({1'b1, b[9]});
        exp_q.push_back({1'b1, b[8]});
        exp_q.push_back({1'b1, 8'h2F});
        exp_q.push_back({1'b1, b[7]});
        exp_q.push_back({1'b1, b[6]});
    endtask

    function automatic logic [87:0] rand88();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[87:0];
    endfunction

    // Monitor: every rising edge of lcd_e is one write, compared against the queue head.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.lcd_e === 1'b1 && prev_e !== 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rs=%0d data=%0h expected no write", bus.lcd_rs, bus.lcd_data);
            end else begin
                mon_word = exp_q.pop_front();
                check("write_rs_data", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, mon_word});
                check("write_rw", {31'd0, bus.lcd_rw}, 32'd0);
            end
        end
        prev_e = bus.lcd_e;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From cycle 0 after reset release, returns first lcd_e-high and first idle cycles.
    task automatic measure_init(output int first_e, output int first_idle);
        first_e    = -1;
        first_idle = -1;
        for (int c = 0; c < 300 && first_idle < 0; c++) begin
            if (bus.lcd_e === 1'b1 && first_e < 0) first_e = c;
            if (bus.busy === 1'b0) first_idle = c;
            else step();
        end
    endtask

    task automatic run_frame(input logic [87:0] v, input bit mid_change);
        int n;
        int fd0;
        bus.lcd_value = v;
        push_frame(v);
        prev_v = v;
        fd0 = fd_cnt;
        bus.refresh = 1'b1;
        step();
        bus.refresh = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            n++;
            if (mid_change && n == 36) bus.lcd_value = rand88();
            step();
        end
        check("frame_busy_cycles", n, 137);
        check("frame_done_count", fd_cnt - fd0, 1);
        check("frame_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int fe;
        int fi;
        int frames;
        int n;
        logic [87:0] v;

        bus.lcd_value = '0;
        bus.refresh   = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, cycle 0
        check("rst_busy", {31'd0, bus.busy}, 1);
        check("rst_e", {31'd0, bus.lcd_e}, 0);
        check("rst_data", {24'd0, bus.lcd_data}, 0);
        check("rst_rs", {31'd0, bus.lcd_rs}, 0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 0);

        push_init();
        measure_init(fe, fi);
        check("first_e_cycle", fe, 21);
        check("init_idle_cycle", fi, 57);
        check("init_queue_empty", exp_q.size(), 0);

        // Reference string frame
        run_frame("T1225123045", 1'b0);

        // Random frames with lcd_value disturbed mid-frame
        for (int i = 0; i < 4; i++) begin
            v = rand88();
            if (v == prev_v) v[0] = ~v[0];
            step();
            run_frame(v, 1'b1);
        end

        // Reset during the pulse of write 3 (cycles 37-38)
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        push_init();
        repeat (37) step();
        check("w3_pulse_e", {31'd0, bus.lcd_e}, 1);
        check("w3_data", {24'd0, bus.lcd_data}, 32'h06);
        reset = 1'b1;
        step();
        check("abort_e", {31'd0, bus.lcd_e}, 0);
        check("abort_busy", {31'd0, bus.busy}, 1);
        check("abort_data", {24'd0, bus.lcd_data}, 0);
        exp_q.delete();
        push_init();
        reset = 1'b0;
        measure_init(fe, fi);
        check("reinit_first_e", fe, 21);
        check("reinit_idle_cycle", fi, 57);
        check("reinit_queue_empty", exp_q.size(), 0);

        v = rand88();
        bus.lcd_value = v;
`ifndef LCD_FRAME_SKIP_EN
        // Refresh held high: three frames, one IDLE cycle between frame_done and LOAD
        repeat (3) push_frame(v);
        bus.refresh = 1'b1;
        frames = 0;
        n = 0;
        while (frames < 3 && n < 2000) begin
            n++;
            if (bus.frame_done === 1'b1) begin
                frames++;
                step();
                check("gap_idle", {31'd0, bus.busy}, 0);
                if (frames == 3) begin
                    bus.refresh = 1'b0;
                end else begin
                    step();
                    check("gap_load", {31'd0, bus.busy}, 1);
                end
            end else begin
                step();
            end
        end
        check("held_frames", frames, 3);
        repeat (20) step();
        check("held_queue_empty", exp_q.size(), 0);
        check("held_stays_idle", {31'd0, bus.busy}, 0);
`else
        // Unchanged content with refresh held: exactly one frame
        push_frame(v);
        frames = fd_cnt;
        bus.refresh = 1'b1;
        repeat (400) step();
        check("skip_one_frame", fd_cnt - frames, 1);
        check("skip_idle", {31'd0, bus.busy}, 0);
        check("skip_queue_empty", exp_q.size(), 0);
        v[7:0] = ~v[7:0];
        bus.lcd_value = v;
        push_frame(v);
        repeat (2) step();
        check("skip_new_frame_started", {31'd0, bus.busy}, 1);
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            n++;
            step();
        end
        repeat (200) step();
        bus.refresh = 1'b0;
        check("skip_second_frame_only", fd_cnt - frames, 2);
        check("skip_queue_empty2", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
